// File: rtl/conv_seq_ctrl_if.sv
// conv_seq_ctrl_if
// Bundle of the sequencer's handshake, BRAM and MAC signals.
//   master : conv_seq_ctrl side (drives enables, addresses, strobes, write port)
//   slave  : fabric side (register slave start bit, BRAMs, MAC accumulator)
// Signals:
//   start_i        start level from reg 10 bit 0
//   busy_o/done_o  run status, done is a one-cycle pulse
//   in_en_o/in_addr_o, w_en_o/w_addr_o       Input / Weight BRAM read port
//   mac_clr_o/mac_en_o/mac_result_i          external MAC control and result
//   out_we_o/out_addr_o/out_wdata_o          OUTACT BRAM write port
interface conv_seq_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start_i;
    logic              busy_o;
    logic              done_o;
    logic              in_en_o;
    logic [ADDR_W-1:0] in_addr_o;
    logic              w_en_o;
    logic [ADDR_W-1:0] w_addr_o;
    logic              mac_clr_o;
    logic              mac_en_o;
    logic [DATA_W-1:0] mac_result_i;
    logic              out_we_o;
    logic [ADDR_W-1:0] out_addr_o;
    logic [DATA_W-1:0] out_wdata_o;

    modport master (
        input  start_i, mac_result_i,
        output busy_o, done_o, in_en_o, in_addr_o, w_en_o, w_addr_o,
               mac_clr_o, mac_en_o, out_we_o, out_addr_o, out_wdata_o
    );

    modport slave (
        output start_i, mac_result_i,
        input  busy_o, done_o, in_en_o, in_addr_o, w_en_o, w_addr_o,
               mac_clr_o, mac_en_o, out_we_o, out_addr_o, out_wdata_o
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl
// Convolution sequencer: on a rising start edge it runs NUM_OUT passes, each
// clearing the MAC, streaming KERNEL_N input/weight reads, draining the MAC
// pipeline and writing the accumulated result to OUTACT.
// Ports:
//   ACLK    PL clock
//   ARESET  synchronous active-high reset
//   bus     conv_seq_ctrl_if.master (start, status, BRAM reads, MAC, OUTACT write)
// Optional feature: define CONV_RELU_EN to clamp negative results to zero.
module conv_seq_ctrl #(
    parameter int KERNEL_N  = 25,
    parameter int NUM_OUT   = 1,
    parameter int IN_STRIDE = 1,
    parameter int MAC_LAT   = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32
) (
    input  logic            ACLK,
    input  logic            ARESET,
    conv_seq_ctrl_if.master bus
);
    localparam int K_W = (KERNEL_N > 1) ? $clog2(KERNEL_N) : 1;
    localparam int J_W = (NUM_OUT  > 1) ? $clog2(NUM_OUT)  : 1;
    localparam int D_W = (MAC_LAT  > 1) ? $clog2(MAC_LAT)  : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              start_q, start_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [J_W-1:0]    j_q, j_d;
    logic [D_W-1:0]    d_q, d_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              in_en_q, in_en_d;
    logic              mac_clr_q, mac_clr_d;
    logic              mac_en_q, mac_en_d;
    logic              out_we_q, out_we_d;
    logic [ADDR_W-1:0] in_addr_q, in_addr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]       in_addr_full_s;
    logic [31:0]       w_addr_full_s;
    logic [31:0]       out_addr_full_s;
    logic [DATA_W-1:0] wdata_s;

    // Next state, counters and outputs; outputs are derived from the next
    // state so that the registered strobes line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        start_d = bus.start_i;
        k_d     = k_q;
        j_d     = j_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !start_q) begin
                    state_d = S_CLR;
                    j_d     = {J_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                k_d     = {K_W{1'b0}};
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (k_q == K_W'(KERNEL_N - 1)) begin
                    state_d = S_DRAIN;
                    d_d     = {D_W{1'b0}};
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            S_DRAIN: begin
                if (d_q == D_W'(MAC_LAT - 1)) begin
                    state_d = S_WRITE;
                end else begin
                    d_d = d_q + D_W'(1);
                end
            end
            S_WRITE: begin
                if (j_q == J_W'(NUM_OUT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + J_W'(1);
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Input address wraps modulo 2^ADDR_W by plain truncation.
        in_addr_full_s  = 32'(j_d) * 32'(IN_STRIDE) + 32'(k_d);
        w_addr_full_s   = 32'(k_d);
        out_addr_full_s = 32'(j_d);

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        in_en_d   = (state_d == S_FETCH);
        mac_clr_d = (state_d == S_CLR);
        // BRAM read data arrives one cycle after the enable.
        mac_en_d  = in_en_q;
        out_we_d  = (state_d == S_WRITE);

        if (state_d == S_FETCH) begin
            in_addr_d = in_addr_full_s[ADDR_W-1:0];
            w_addr_d  = w_addr_full_s[ADDR_W-1:0];
        end else begin
            in_addr_d = in_addr_q;
            w_addr_d  = w_addr_q;
        end

        if (state_d == S_WRITE) begin
            out_addr_d = out_addr_full_s[ADDR_W-1:0];
        end else begin
            out_addr_d = out_addr_q;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            k_q        <= {K_W{1'b0}};
            j_q        <= {J_W{1'b0}};
            d_q        <= {D_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_en_q    <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            out_we_q   <= 1'b0;
            in_addr_q  <= {ADDR_W{1'b0}};
            w_addr_q   <= {ADDR_W{1'b0}};
            out_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            k_q        <= k_d;
            j_q        <= j_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_en_q    <= in_en_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            out_we_q   <= out_we_d;
            in_addr_q  <= in_addr_d;
            w_addr_q   <= w_addr_d;
            out_addr_q <= out_addr_d;
        end
    end

    // Write data is a direct path from the MAC: the last tap only becomes
    // visible on mac_result_i in the WRITE cycle itself, so registering it
    // would cost a cycle of latency.
    always_comb begin
`ifdef CONV_RELU_EN
        if (bus.mac_result_i[DATA_W-1]) begin
            wdata_s = {DATA_W{1'b0}};
        end else begin
            wdata_s = bus.mac_result_i;
        end
`else
        wdata_s = bus.mac_result_i;
`endif
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.in_en_o     = in_en_q;
    assign bus.w_en_o      = in_en_q;
    assign bus.in_addr_o   = in_addr_q;
    assign bus.w_addr_o    = w_addr_q;
    assign bus.mac_clr_o   = mac_clr_q;
    assign bus.mac_en_o    = mac_en_q;
    assign bus.out_we_o    = out_we_q;
    assign bus.out_addr_o  = out_addr_q;
    assign bus.out_wdata_o = wdata_s;
endmodule
